hexseg_capture: RTL
===================

Name: hexseg_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Watches a multiplexed 7-segment display bus: active-high segments plus active-low digit selects.
- Decodes each digit's segment pattern back to a 4-bit hex nibble and holds a per-digit value/valid register.
- Used for display loopback self-test and for snooping a front-panel display driven by other logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (digit-select width).
- STABLE_CYCLES, 3, consecutive identical samples required before a pattern is accepted (>=1).
- STALE_CYCLES, 1024, cycles without an accepted refresh before a digit's valid clears (>=2).
- STALE_W, 11, width of the per-digit stale counter; must hold STALE_CYCLES.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- segment, input, 7, segment lines, active high; bit0=B, 1=G, 2=C, 3=F, 4=A, 5=D, 6=E.
- digit_n, input, NUM_DIGITS, digit selects, active low.
- value, output, 4*NUM_DIGITS, captured nibbles; digit k is at [4k+3:4k].
- valid, output, NUM_DIGITS, digit k holds a fresh decoded value.
- blank, output, NUM_DIGITS, digit k last accepted all-off pattern (7'h00).
- update, output, 1, one-cycle pulse on each acceptance.
- update_digit, output, $clog2(NUM_DIGITS), index of the digit accepted (meaningful while update=1).
- error, output, 1, one-cycle pulse when a stable pattern matches no glyph.

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, reset_n.
- Reset: every output and every internal register goes to 0.
- Input stage: segment and digit_n are registered once (s_seg, s_dig). The previous sample is also held for comparison.
- Selection:
  - A sample is "selected" when exactly one bit of s_dig is 0.
  - All-high, or two or more low, means not selected.
- Decode table (pattern -> nibble), 7'h:
  - 7D->0, 05->1, 73->2, 37->3, 0F->4, 3E->5, 7E->6, 15->7
  - 7F->8, 3F->9, 5F->A, 6E->B, 78->C, 67->D, 7A->E, 5A->F
  - 00 -> blank.
  - Anything else is invalid.
- FSM states: IDLE, TRACK, HOLD.
- IDLE:
  - If the sample is selected, load cnt=1 and go to TRACK.
  - Otherwise stay in IDLE.
- TRACK:
  - Sample equals previous sample and is selected: cnt++.
  - Sample differs but is selected: cnt=1, stay in TRACK.
  - Sample not selected: go to IDLE.
  - cnt reaching STABLE_CYCLES triggers acceptance on that edge, then go to HOLD.
- HOLD:
  - Stay while the sample is unchanged.
  - Any change: selected goes to TRACK with cnt=1; not selected goes to IDLE.
  - No repeat acceptance while in HOLD.
- Acceptance of digit k, registered outputs on the same edge:
  - Valid glyph: value[k]=nibble, valid[k]=1, blank[k]=0, update=1, update_digit=k.
  - Blank (7'h00): value[k] unchanged, valid[k]=0, blank[k]=1, update=1.
  - Invalid pattern: error=1. value, valid and blank unchanged; update=0.
- Latency: a pattern applied at the pins for STABLE_CYCLES edges produces update STABLE_CYCLES+1 edges after its first pin sample. With STABLE_CYCLES=1, acceptance occurs on the first selected sample.
- Stale counters, one per digit:
  - Cleared on acceptance of that digit.
  - Otherwise incremented, saturating.
  - On reaching STALE_CYCLES: valid[k]=0 and blank[k]=0; value[k] is retained.
  - Acceptance and stale timeout on the same edge: acceptance wins.
- Reset asserted mid-track: the FSM returns to IDLE asynchronously and every output clears, including the pending count.

Optional Feature:
- Macro: HEXSEG_CAPTURE_ERRCNT_EN.
- Defined: adds output err_count[7:0].
  - Increments on each error pulse and saturates at 8'hFF.
  - Cleared by reset and by new input err_clr (1 bit, synchronous). err_clr takes priority over a simultaneous increment.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Scan digits 0..3 with patterns 7'h7D, 7'h05, 7'h73, 7'h37 for 3 cycles each, with one idle cycle (digit_n=4'hF) between digits. Required: four update pulses with update_digit 0,1,2,3; value=16'h3210; valid=4'hF.
- digit_n=4'hE with segment 7'h5A held 2 cycles, then changed. Required: no update and value unchanged. Holding 3 cycles then gives value[3:0]=4'hF.
- digit_n=4'hC (two digits low) with 7'h7F held 10 cycles. Required: no update, no error.
- digit_n=4'hB with 7'h01 held 5 cycles. Required: exactly one error pulse; valid[2] and value unchanged. Under ERRCNT_EN, err_count=1.
- Accept 7'h6E on digit 1, then no activity for 1024 cycles. Required: valid[1] falls after STALE_CYCLES; value[7:4] stays 4'hB.
- Assert reset_n=0 during TRACK at cnt=2. Required: all outputs 0 immediately. After release, a 3-cycle hold of 7'h7A on digit 0 gives value[3:0]=4'hE.

Source files
------------

// File: rtl/hexseg_capture_if.sv
// Display bus plus decoded-capture outputs for hexseg_capture; err_clr/err_count exist only with HEXSEG_CAPTURE_ERRCNT_EN.
// Latency: none (wires only). Backpressure: none, the display bus is free-running.
// master = display driver / observer side, slave = capture block.
interface hexseg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              segment;
    logic [NUM_DIGITS-1:0]   digit_n;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   valid;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    update;
    logic [IDX_W-1:0]        update_digit;
    logic                    error;
`ifdef HEXSEG_CAPTURE_ERRCNT_EN
    logic                    err_clr;
    logic [7:0]              err_count;

    modport master (output segment, digit_n, err_clr,
                    input  value, valid, blank, update, update_digit, error, err_count);
    modport slave  (input  segment, digit_n, err_clr,
                    output value, valid, blank, update, update_digit, error, err_count);
`else
    modport master (output segment, digit_n,
                    input  value, valid, blank, update, update_digit, error);
    modport slave  (input  segment, digit_n,
                    output value, valid, blank, update, update_digit, error);
`endif
endinterface

// File: rtl/hexseg_capture.sv
// Decodes a multiplexed 7-segment bus back to per-digit hex nibbles; HEXSEG_CAPTURE_ERRCNT_EN adds err_count/err_clr.
// Latency: update fires on the (STABLE_CYCLES+1)th edge counting the first pin sample of a stable pattern.
// Backpressure: none; passive snooper, every sample is consumed.
module hexseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int STALE_CYCLES  = 1024,
    parameter int STALE_W       = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    hexseg_capture_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [6:0]              s_seg, p_seg;
    logic [NUM_DIGITS-1:0]   s_dig, p_dig;
    state_t                  state, nxt;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   valid_q, blank_q;
    logic                    update_q, error_q;
    logic [IDX_W-1:0]        update_digit_q;
    logic [STALE_W-1:0]      stale_q [NUM_DIGITS];

    logic                    sel, same, accept, glyph_ok, blank_pat;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W:0]          low_cnt;
    logic [3:0]              nibble;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7D: decode = 5'h10;  7'h05: decode = 5'h11;
            7'h73: decode = 5'h12;  7'h37: decode = 5'h13;
            7'h0F: decode = 5'h14;  7'h3E: decode = 5'h15;
            7'h7E: decode = 5'h16;  7'h15: decode = 5'h17;
            7'h7F: decode = 5'h18;  7'h3F: decode = 5'h19;
            7'h5F: decode = 5'h1A;  7'h6E: decode = 5'h1B;
            7'h78: decode = 5'h1C;  7'h67: decode = 5'h1D;
            7'h7A: decode = 5'h1E;  7'h5A: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Selected means exactly one active-low select asserted.
    always_comb begin
        low_cnt = '0;
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_dig[i]) begin
                low_cnt = low_cnt + (IDX_W+1)'(1);
                idx     = IDX_W'(i);
            end
        end
        sel = (low_cnt == (IDX_W+1)'(1));
    end

    assign same      = (s_seg == p_seg) && (s_dig == p_dig);
    assign glyph_ok  = decode(s_seg) >= 5'h10;
    assign nibble    = decode(s_seg)[3:0];
    assign blank_pat = (s_seg == 7'h00);

    always_comb begin
        nxt    = state;
        cnt_n  = cnt;
        accept = 1'b0;
        case (state)
            IDLE: if (sel) begin
                cnt_n = CNT_W'(1);
                nxt   = TRACK;
            end
            TRACK: begin
                if (!sel)      nxt   = IDLE;
                else if (same) cnt_n = cnt + CNT_W'(1);
                else           cnt_n = CNT_W'(1);
            end
            HOLD: if (!same) begin
                if (sel) begin
                    cnt_n = CNT_W'(1);
                    nxt   = TRACK;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
        // Stability reached: accept on this edge and park in HOLD so it fires once.
        if (nxt == TRACK && cnt_n >= CNT_W'(STABLE_CYCLES)) begin
            accept = 1'b1;
            nxt    = HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_seg          <= '0;
            s_dig          <= '0;
            p_seg          <= '0;
            p_dig          <= '0;
            state          <= IDLE;
            cnt            <= '0;
            value_q        <= '0;
            valid_q        <= '0;
            blank_q        <= '0;
            update_q       <= 1'b0;
            update_digit_q <= '0;
            error_q        <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) stale_q[k] <= '0;
        end else begin
            s_seg    <= bus.segment;
            s_dig    <= bus.digit_n;
            p_seg    <= s_seg;
            p_dig    <= s_dig;
            state    <= nxt;
            cnt      <= cnt_n;
            update_q <= 1'b0;
            error_q  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (stale_q[k] != STALE_W'(STALE_CYCLES)) begin
                    stale_q[k] <= stale_q[k] + STALE_W'(1);
                    if (stale_q[k] == STALE_W'(STALE_CYCLES - 1)) begin
                        valid_q[k] <= 1'b0;
                        blank_q[k] <= 1'b0;
                    end
                end
            end
            // Placed after the stale loop so acceptance overrides a same-edge timeout.
            if (accept) begin
                if (blank_pat) begin
                    valid_q[idx]   <= 1'b0;
                    blank_q[idx]   <= 1'b1;
                    update_q       <= 1'b1;
                    update_digit_q <= idx;
                    stale_q[idx]   <= '0;
                end else if (glyph_ok) begin
                    value_q[4*int'(idx) +: 4] <= nibble;
                    valid_q[idx]   <= 1'b1;
                    blank_q[idx]   <= 1'b0;
                    update_q       <= 1'b1;
                    update_digit_q <= idx;
                    stale_q[idx]   <= '0;
                end else begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    assign bus.value        = value_q;
    assign bus.valid        = valid_q;
    assign bus.blank        = blank_q;
    assign bus.update       = update_q;
    assign bus.update_digit = update_digit_q;
    assign bus.error        = error_q;

`ifdef HEXSEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count_q <= '0;
        else if (bus.err_clr)
            err_count_q <= '0;
        else if (accept && !blank_pat && !glyph_ok && err_count_q != 8'hFF)
            err_count_q <= err_count_q + 8'd1;
    end

    assign bus.err_count = err_count_q;
`endif
endmodule
